// File: rtl/ma_xif_issue_buffer_pkg.sv
// Shared matrix-accelerator types: the claimed major opcode and the issue-buffer entry.
// Entry payload fields are sized for the widest supported XLEN/ID; instances use the low bits.
package ma_xif_issue_buffer_pkg;

  localparam logic [6:0] MA_XIF_OPCODE = 7'h2B;
  localparam int         MA_XLEN_MAX   = 64;
  localparam int         MA_ID_MAX     = 16;

  typedef struct packed {
    logic [31:0]            instr;
    logic [MA_ID_MAX-1:0]   id;
    logic [MA_XLEN_MAX-1:0] rs0;
    logic [MA_XLEN_MAX-1:0] rs1;
    logic                   committed;
    logic                   killed;
  } ma_xif_entry_t;

endpackage

// File: rtl/ma_xif_issue_buffer_if.sv
// Issue/commit/dispatch bundle between the core-side X-IF and the accelerator decoder.
// master = core + decoder side, slave = issue buffer.
interface ma_xif_issue_buffer_if #(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4
);
  logic                    issue_valid;
  logic                    issue_ready;
  logic [31:0]             issue_instr;
  logic [ID_WIDTH-1:0]     issue_id;
  logic [XLEN-1:0]         issue_rs0;
  logic [XLEN-1:0]         issue_rs1;
  logic                    issue_accept;
  logic                    commit_valid;
  logic [ID_WIDTH-1:0]     commit_id;
  logic                    commit_kill;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [31:0]             instr_o;
  logic [XLEN-1:0]         rs0_o;
  logic [XLEN-1:0]         rs1_o;
  logic [ID_WIDTH-1:0]     id_o;
  logic [$clog2(DEPTH):0]  occupancy;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1,
           commit_valid, commit_id, commit_kill, instr_ready,
    input  issue_ready, issue_accept, instr_valid, instr_o, rs0_o, rs1_o, id_o, occupancy
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1,
           commit_valid, commit_id, commit_kill, instr_ready,
    output issue_ready, issue_accept, instr_valid, instr_o, rs0_o, rs1_o, id_o, occupancy
  );
endinterface

// File: rtl/ma_xif_id_match.sv
// Finds the oldest live buffer slot holding a given instruction id; purely combinational.
// No state, no backpressure; result is valid whenever hit_o is set.
module ma_xif_id_match #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic [DEPTH-1:0][ID_WIDTH-1:0] ids_i,
  input  logic [DEPTH-1:0]               live_i,
  input  logic [$clog2(DEPTH)-1:0]       head_i,
  input  logic [ID_WIDTH-1:0]            id_i,
  output logic [$clog2(DEPTH)-1:0]       idx_o,
  output logic                           hit_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot;

  // Walk youngest to oldest so the oldest match is the last one written.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    slot  = '0;
    for (int a = DEPTH - 1; a >= 0; a--) begin
      slot = head_i + PTR_W'(a);
      if (live_i[slot] && (ids_i[slot] == id_i)) begin
        idx_o = slot;
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ma_xif_issue_buffer.sv
// Claims OPCODE offers from the core and releases them downstream in program order once committed.
// Head visible one cycle after enqueue+commit; issue_ready drops when full, payload held while instr_ready is low.
module ma_xif_issue_buffer
  import ma_xif_issue_buffer_pkg::*;
#(
  parameter logic [6:0] OPCODE   = MA_XIF_OPCODE,
  parameter int         DEPTH    = 4,
  parameter int         XLEN     = 32,
  parameter int         ID_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ma_xif_issue_buffer_if.slave xif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] cmt_q, cmt_d;
  logic [DEPTH-1:0] kill_q, kill_d;
  ma_xif_entry_t    mem_q [DEPTH];

  logic [DEPTH-1:0]               live;
  logic [DEPTH-1:0][ID_WIDTH-1:0] ids;
  logic [PTR_W-1:0]               hit_idx;
  logic                           hit;
  logic                           enq;
  logic                           pop;
  logic                           head_live;
  logic                           late_hit;
  ma_xif_entry_t                  new_ent;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] age;
    assign age     = PTR_W'(g) - head_q;
    assign live[g] = {1'b0, age} < occ_q;
    assign ids[g]  = mem_q[g].id[ID_WIDTH-1:0];
  end

  ma_xif_id_match #(
    .DEPTH    (DEPTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_id_match (
    .ids_i  (ids),
    .live_i (live),
    .head_i (head_q),
    .id_i   (xif.commit_id),
    .idx_o  (hit_idx),
    .hit_o  (hit)
  );

  assign head_live        = (occ_q != '0);
  assign xif.issue_ready  = occ_q < OCC_W'(DEPTH);
  assign xif.issue_accept = xif.issue_valid && (xif.issue_instr[6:0] == OPCODE);
  assign xif.instr_valid  = head_live && cmt_q[head_q] && !kill_q[head_q];
  assign enq = xif.issue_valid && xif.issue_ready && xif.issue_accept;
  // A killed head drains on its own, one entry per cycle, never shown downstream.
  assign pop = (xif.instr_valid && xif.instr_ready) || (head_live && kill_q[head_q]);

  // A commit that finds no older owner belongs to the instruction entering this cycle.
  assign late_hit = xif.commit_valid && !hit && enq && (xif.commit_id == xif.issue_id);

  always_comb begin
    new_ent           = '0;
    new_ent.instr     = xif.issue_instr;
    new_ent.id        = MA_ID_MAX'(xif.issue_id);
    new_ent.rs0       = MA_XLEN_MAX'(xif.issue_rs0);
    new_ent.rs1       = MA_XLEN_MAX'(xif.issue_rs1);
    new_ent.committed = late_hit && !xif.commit_kill;
    new_ent.killed    = late_hit && xif.commit_kill;
  end

  always_comb begin
    cmt_d  = cmt_q;
    kill_d = kill_q;
    if (xif.commit_valid && hit) begin
      if (xif.commit_kill) kill_d[hit_idx] = 1'b1;
      else                 cmt_d[hit_idx]  = 1'b1;
    end
    if (pop) begin
      cmt_d[head_q]  = 1'b0;
      kill_d[head_q] = 1'b0;
    end
    if (enq) begin
      cmt_d[tail_q]  = new_ent.committed;
      kill_d[tail_q] = new_ent.killed;
    end
  end

  assign head_d = head_q + PTR_W'(pop);
  assign tail_d = tail_q + PTR_W'(enq);
  assign occ_d  = occ_q + OCC_W'(enq) - OCC_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      cmt_q  <= '0;
      kill_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cmt_q  <= cmt_d;
      kill_q <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= new_ent;
  end

  assign xif.instr_o   = mem_q[head_q].instr;
  assign xif.rs0_o     = mem_q[head_q].rs0[XLEN-1:0];
  assign xif.rs1_o     = mem_q[head_q].rs1[XLEN-1:0];
  assign xif.id_o      = mem_q[head_q].id[ID_WIDTH-1:0];
  assign xif.occupancy = occ_q;

endmodule
